mul32: RTL
==========

Name: mul32

Overview:
- Iterative 32x32 shift-add multiplier for the RISC-V M-extension multiply ops: MUL, MULH, MULHSU, MULHU.
- Companion to the iterative divider. Uses the same held-valid/ready handshake so the execute stage drives both units identically.
- Returns either the low or the high 32-bit word of the 64-bit product.

Parameters:
- none (width fixed at 32; iteration count set only by the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  32  multiplicand (rs1).
- b  input  32  multiplier (rs2).
- a_signed  input  1  treat a as two's complement.
- b_signed  input  1  treat b as two's complement.
- high  input  1  0 = return product[31:0], 1 = return product[63:32].
- valid  input  1  request; held high by the requester until it has consumed ready.
- result  output  32  selected product word.
- ready  output  1  result valid; stays high while valid stays high.

Behaviour:
- Reset (synchronous, active-high): state = IDLE, ready = 0, result = 0, internal counter/accumulator cleared. Reset wins over valid in the same cycle.
- Reset mid-operation: the operation is aborted with no partial result written, and the block returns to IDLE.
- State machine: IDLE, RUN, DONE.
- IDLE, valid = 1 at edge N:
  - capture operands and modes.
  - sign = (a_signed & a[31]) ^ (b_signed & b[31]).
  - mcand (64-bit) = zero-extended |a|; mplier (32-bit) = |b|.
  - |x| = 0 - x when that operand's signed flag and bit 31 are set, otherwise x. 0x80000000 maps to 0x80000000, treated as unsigned.
  - acc = 0, count = 0; go to RUN.
- IDLE, valid = 0: stay in IDLE, ready = 0.
- RUN, each edge with valid = 1:
  - if mplier[0] = 1, acc <= acc + mcand (64-bit, wraps modulo 2^64, never overflows for legal inputs).
  - mcand <<= 1; mplier >>= 1; count++.
  - After 32 iterations (count = 32), the next edge goes to DONE.
- Entering DONE: p = sign ? (0 - acc) : acc, in 64 bits. result <= high ? p[63:32] : p[31:0]; ready <= 1.
- Latency: valid first sampled high at edge N gives ready = 1 and result valid after edge N+33.
- DONE: hold ready = 1 and result while valid = 1. When valid = 0 at an edge, go to IDLE with ready <= 0.
- valid dropped in RUN: abort to IDLE, ready stays 0, result unchanged. A re-asserted valid starts a fresh operation with freshly captured operands.
- Operands and mode bits are sampled only on the IDLE->RUN edge. Changes during RUN or DONE are ignored.
- result holds its last value from DONE until the next completion or reset. Consumers qualify it with ready.
- Back-to-back operations need valid low for at least one edge between them. Minimum issue interval is 35 edges.

Optional Feature:
- Macro: MUL32_RADIX4_EN.
- Defined:
  - Each RUN iteration consumes mplier[1:0]: add 0, mcand, mcand<<1, or (mcand<<1)+mcand.
  - Then mcand <<= 2, mplier >>= 2.
  - RUN lasts 16 iterations; ready and result valid after edge N+17.
  - All other behaviour is identical.
- Undefined: radix-2 datapath as above, latency N+33.

Test Plan:
- MUL: a=7, b=6, a_signed=b_signed=1, high=0, valid raised at edge N -> ready=0 through edge N+32, ready=1 with result=0x0000002A after N+33 (N+17 with MUL32_RADIX4_EN).
- MULH and MUL, signed x signed: a=b=0xFFFFFFFF -> high=1 gives 0x00000000, high=0 gives 0x00000001.
- MULH, signed x signed: a=b=0x80000000 -> high=1 gives 0x40000000, high=0 gives 0x00000000.
- MULHU vs MULHSU:
  - a=b=0xFFFFFFFF unsigned: high=1 gives 0xFFFFFFFE, high=0 gives 0x00000001.
  - Same operands with a_signed=1, b_signed=0: high=1 gives 0xFFFFFFFF, low=0x00000001.
- Abort: start a=0x12345678, b=0x9ABCDEF0, drop valid after 10 RUN edges. Then raise valid with a=3, b=5 unsigned, high=0 -> ready=0 until 33 edges after the new start, result=0x0000000F. Valid held high for 5 more edges -> ready and result stable. Valid low -> ready=0 after the next edge.
- Reset mid-run: pulse reset for one cycle at RUN count=20 -> ready=0, result=0. Next request a=2, b=0xFFFFFFFD, both signed, high=0 -> result=0xFFFFFFFA after N+33.

Source files
------------

// File: rtl/mul32.sv
// Iterative 32x32 shift-add multiplier for RISC-V MUL/MULH/MULHSU/MULHU.
// Define MUL32_RADIX4_EN to retire two multiplier bits per RUN cycle.
module mul32 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        a_signed,
    input  logic        b_signed,
    input  logic        high,
    input  logic        valid,
    output logic [31:0] result,
    output logic        ready
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

`ifdef MUL32_RADIX4_EN
    localparam logic [5:0] LastCount = 6'd16;
`else
    localparam logic [5:0] LastCount = 6'd32;
`endif

    state_t      state_q, state_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [63:0] acc_q, acc_d;
    logic [5:0]  count_q, count_d;
    logic        sign_q, sign_d;
    logic        high_q, high_d;
    logic [31:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [63:0] addend;
    logic [63:0] product;

    // 0x80000000 negates to itself and is then treated as an unsigned magnitude.
    assign a_neg = a_signed & a[31];
    assign b_neg = b_signed & b[31];
    assign a_mag = a_neg ? (32'd0 - a) : a;
    assign b_mag = b_neg ? (32'd0 - b) : b;

    assign product = sign_q ? (64'd0 - acc_q) : acc_q;

    always_comb begin
`ifdef MUL32_RADIX4_EN
        unique case (mplier_q[1:0])
            2'd0:    addend = 64'd0;
            2'd1:    addend = mcand_q;
            2'd2:    addend = mcand_q << 1;
            default: addend = (mcand_q << 1) + mcand_q;
        endcase
`else
        addend = mplier_q[0] ? mcand_q : 64'd0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        count_d  = count_q;
        sign_d   = sign_q;
        high_d   = high_q;
        result_d = result_q;
        ready_d  = ready_q;

        unique case (state_q)
            StIdle: begin
                ready_d = 1'b0;
                if (valid) begin
                    mcand_d  = {32'd0, a_mag};
                    mplier_d = b_mag;
                    sign_d   = a_neg ^ b_neg;
                    high_d   = high;
                    acc_d    = 64'd0;
                    count_d  = 6'd0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                if (!valid) begin
                    state_d = StIdle;
                end else if (count_q == LastCount) begin
                    result_d = high_q ? product[63:32] : product[31:0];
                    ready_d  = 1'b1;
                    state_d  = StDone;
                end else begin
                    acc_d   = acc_q + addend;
                    count_d = count_q + 6'd1;
`ifdef MUL32_RADIX4_EN
                    mcand_d  = mcand_q << 2;
                    mplier_d = mplier_q >> 2;
`else
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
`endif
                end
            end
            StDone: begin
                if (!valid) begin
                    ready_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            count_q  <= 6'd0;
            sign_q   <= 1'b0;
            high_q   <= 1'b0;
            result_q <= 32'd0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            sign_q   <= sign_d;
            high_q   <= high_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;

endmodule
